// File: rtl/fp_add_normalize.sv
// Signed-magnitude fraction adder with a one-bit-per-cycle renormaliser.
// Sits after operand alignment; both operands share in_1's exponent.
module fp_add_normalize #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 18
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W+FRAC_W:0]     in_1,
    input  logic [EXP_W+FRAC_W:0]     in_2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     out,
    output logic                      out_zero,
    output logic                      out_overflow
);

    localparam int W = 1 + EXP_W + FRAC_W;
    localparam logic [EXP_W-1:0] EXP_MAX = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic [EXP_W-1:0] EXP_MIN = {1'b1, {(EXP_W-1){1'b0}}};

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never drops before that edge and the payload
    // stays constant while valid is high.

    typedef enum logic [1:0] {IDLE, ADD, NORM, DONE} state_t;

    state_t              state, state_next;
    logic                s1_q, s2_q, s1_next, s2_next;
    logic [FRAC_W-1:0]   f1_q, f2_q, f1_next, f2_next;
    logic [FRAC_W:0]     sum_q, sum_next;
    logic [EXP_W-1:0]    exp_q, exp_next;
    logic                sign_q, sign_next;
    logic [W-1:0]        out_q, out_next;
    logic                zero_q, zero_next;
    logic                ovf_q, ovf_next;
    logic                valid_q, valid_next;

    // in_2's exponent equals in_1's after alignment, so it is never read.
    logic unused_in_2_exp;
    assign unused_in_2_exp = ^in_2[W-2:FRAC_W];

    always_comb begin
        state_next = state;
        s1_next    = s1_q;
        s2_next    = s2_q;
        f1_next    = f1_q;
        f2_next    = f2_q;
        sum_next   = sum_q;
        exp_next   = exp_q;
        sign_next  = sign_q;
        out_next   = out_q;
        zero_next  = zero_q;
        ovf_next   = ovf_q;
        valid_next = valid_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    s1_next    = in_1[W-1];
                    s2_next    = in_2[W-1];
                    f1_next    = in_1[FRAC_W-1:0];
                    f2_next    = in_2[FRAC_W-1:0];
                    exp_next   = in_1[W-2:FRAC_W];
                    zero_next  = 1'b0;
                    ovf_next   = 1'b0;
                    state_next = ADD;
                end
            end
            ADD: begin
                if (s1_q == s2_q) begin
                    sum_next  = {1'b0, f1_q} + {1'b0, f2_q};
                    sign_next = s1_q;
                end else if (f1_q >= f2_q) begin
                    sum_next  = {1'b0, f1_q - f2_q};
                    sign_next = s1_q;
                end else begin
                    sum_next  = {1'b0, f2_q - f1_q};
                    sign_next = s2_q;
                end
                state_next = NORM;
            end
            NORM: begin
                if (sum_q == '0) begin
                    out_next   = {1'b0, EXP_MIN, {FRAC_W{1'b0}}};
                    zero_next  = 1'b1;
                    state_next = DONE;
                end else if (sum_q[FRAC_W] && exp_q == EXP_MAX) begin
                    out_next   = {sign_q, EXP_MAX, {FRAC_W{1'b1}}};
                    ovf_next   = 1'b1;
                    state_next = DONE;
                end else if (sum_q[FRAC_W]) begin
                    sum_next = sum_q >> 1;
                    exp_next = exp_q + EXP_W'(1);
                end else if (!sum_q[FRAC_W-1] && exp_q == EXP_MIN) begin
                    // Exponent floor reached: the value leaves as a denormal.
                    out_next   = {sign_q, exp_q, sum_q[FRAC_W-1:0]};
                    state_next = DONE;
                end else if (!sum_q[FRAC_W-1]) begin
                    sum_next = sum_q << 1;
                    exp_next = exp_q - EXP_W'(1);
                end else begin
                    out_next   = {sign_q, exp_q, sum_q[FRAC_W-1:0]};
                    state_next = DONE;
                end
            end
            DONE: begin
                // First DONE cycle raises out_valid; the result is already held.
                if (!valid_q) begin
                    valid_next = 1'b1;
                end else if (out_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            f1_q    <= '0;
            f2_q    <= '0;
            sum_q   <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            s1_q    <= s1_next;
            s2_q    <= s2_next;
            f1_q    <= f1_next;
            f2_q    <= f2_next;
            sum_q   <= sum_next;
            exp_q   <= exp_next;
            sign_q  <= sign_next;
            out_q   <= out_next;
            zero_q  <= zero_next;
            ovf_q   <= ovf_next;
            valid_q <= valid_next;
        end
    end

    assign in_ready     = (state == IDLE);
    assign out_valid    = valid_q;
    assign out          = out_q;
    assign out_zero     = zero_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_fp_add_normalize.sv
// Directed bench for fp_add_normalize: hand-computed vectors, latency,
// backpressure and mid-operation reset.
module tb_fp_add_normalize;

    localparam int W = 27;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_1;
    logic [W-1:0] in_2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         out_zero;
    logic         out_overflow;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    fp_add_normalize dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_1         (in_1),
        .in_2         (in_2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out          (out),
        .out_zero     (out_zero),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic s, input logic [7:0] e, input logic [17:0] f);
        return {s, e, f};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res, input logic ez, input logic eo,
                          input int lat, input int hold);
        int n;
        logic [W-1:0] e;
        exp_q.push_back(res);
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready_before"}, W'(in_ready), W'(1));
        in_1     = a;
        in_2     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_ready_busy"}, W'(in_ready), W'(0));
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, W'(n), W'(lat));
        e = exp_q.pop_front();
        check({tag, "_out"}, out, e);
        check({tag, "_zero"}, W'(out_zero), W'(ez));
        check({tag, "_ovf"}, W'(out_overflow), W'(eo));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_out"}, out, e);
            check({tag, "_hold_valid"}, W'(out_valid), W'(1));
            check({tag, "_hold_ready"}, W'(in_ready), W'(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_cleared"}, W'(out_valid), W'(0));
        check({tag, "_ready_after"}, W'(in_ready), W'(1));
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_1      = '0;
        in_2      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_out", out, '0);
        check("rst_valid", W'(out_valid), W'(0));
        check("rst_zero", W'(out_zero), W'(0));
        check("rst_ovf", W'(out_overflow), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));

        // 1.0 + 1.0 = 2.0: one right shift
        run_op("one_plus_one", mk(0, 8'h00, 18'h20000), mk(0, 8'h00, 18'h20000),
               mk(0, 8'h01, 18'h20000), 1'b0, 1'b0, 4, 0);
        // 1.0 - 0.75 = 0.25: two left shifts
        run_op("cancel", mk(0, 8'h00, 18'h20000), mk(1, 8'h00, 18'h18000),
               mk(0, 8'hFE, 18'h20000), 1'b0, 1'b0, 5, 0);
        run_op("exact_cancel", mk(0, 8'h05, 18'h2A000), mk(1, 8'h05, 18'h2A000),
               mk(0, 8'h80, 18'h00000), 1'b1, 1'b0, 3, 0);
        run_op("overflow", mk(0, 8'h7F, 18'h3FFFF), mk(0, 8'h7F, 18'h3FFFF),
               mk(0, 8'h7F, 18'h3FFFF), 1'b0, 1'b1, 3, 0);
        run_op("denormal", mk(0, 8'h80, 18'h00100), mk(0, 8'h80, 18'h00100),
               mk(0, 8'h80, 18'h00200), 1'b0, 1'b0, 3, 0);
        // in_2 larger in magnitude: result takes in_2's sign, already normalised
        run_op("b_larger", mk(0, 8'h03, 18'h10000), mk(1, 8'h03, 18'h30000),
               mk(1, 8'h03, 18'h20000), 1'b0, 1'b0, 3, 0);
        // negative result needing one left shift: 0x18000 -> 0x30000
        run_op("neg_shift", mk(1, 8'h00, 18'h20000), mk(0, 8'h00, 18'h08000),
               mk(1, 8'hFF, 18'h30000), 1'b0, 1'b0, 4, 0);
        run_op("backpressure", mk(0, 8'h00, 18'h20000), mk(0, 8'h00, 18'h20000),
               mk(0, 8'h01, 18'h20000), 1'b0, 1'b0, 4, 5);

        // Reset while the cancellation case is in NORM
        in_1     = mk(0, 8'h00, 18'h20000);
        in_2     = mk(1, 8'h00, 18'h18000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", W'(out_valid), W'(0));
        check("midrst_in_ready", W'(in_ready), W'(1));
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) n++;
        end
        check("midrst_never_emitted", W'(n), W'(0));

        run_op("after_reset", mk(0, 8'h00, 18'h20000), mk(1, 8'h00, 18'h18000),
               mk(0, 8'hFE, 18'h20000), 1'b0, 1'b0, 5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
